cntr_gray_seq: RTL and testbench

Sequencer that drives the `cen` input of the `cntr_gray` Gray-code counter. It issues a programmed burst of enable pulses with a programmable idle gap, or runs continuously until aborted. It checks that every enabled step moves the counter's Gray `count` by exactly one bit. It sits between the control logic (or a bench stimulus generator) and `cntr_gray`, and replaces free-running `cen` generation.

---
 rtl/cntr_gray_pkg.sv | 19 +
 rtl/gray_step_chk.sv | 18 +
 rtl/cntr_gray_seq.sv | 132 +++++++++++++
 tb/tb_cntr_gray_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_gray_pkg.sv
// Shared types and constants for the Gray-counter enable sequencer.
package cntr_gray_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  localparam logic MODE_BURST = 1'b0;
  localparam logic MODE_CONT  = 1'b1;

  // ST_FLUSH is the one-cycle transit after the last burst pulse, holding busy
  // while the final step check lands before done is raised.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_FLUSH,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/gray_step_chk.sv
// Combinational check that two Gray count words differ in exactly one bit.
module gray_step_chk #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_a,
  input  logic [WIDTH-1:0] count_b,
  output logic             one_step
);

  logic [WIDTH-1:0] diff;

  // A single set bit is a nonzero power of two: clearing the lowest set bit leaves zero.
  always_comb begin
    diff     = count_a ^ count_b;
    one_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/cntr_gray_seq.sv
// Enable sequencer for cntr_gray: programmed bursts or continuous runs of cen
// pulses with a programmable gap, plus a one-bit-per-step check on the count.
module cntr_gray_seq
  import cntr_gray_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = 8,
  parameter int unsigned GAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [STEP_W-1:0] steps,
  input  logic [GAP_W-1:0]  gap,
  input  logic              abort,
  input  logic [WIDTH-1:0]  count_in,
  output logic              cen,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_t        state_q, state_nx;
  logic              mode_q, mode_nx;
  logic [STEP_W-1:0] steps_q, steps_nx;
  logic [GAP_W-1:0]  gap_q, gap_nx;
  logic [GAP_W-1:0]  gcnt_q, gcnt_nx;
  logic [WIDTH-1:0]  prev_q;
  logic              chk_pend_q;
  logic              accept;
  logic              step_ok;

  gray_step_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .count_a  (count_in),
    .count_b  (prev_q),
    .one_step (step_ok)
  );

  always_comb begin
    state_nx = state_q;
    mode_nx  = mode_q;
    steps_nx = steps_q;
    gap_nx   = gap_q;
    gcnt_nx  = gcnt_q;
    accept   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          accept   = 1'b1;
          mode_nx  = mode;
          steps_nx = steps;
          gap_nx   = gap;
          if (mode == MODE_BURST && steps == '0) state_nx = ST_DONE;
          else                                   state_nx = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (mode_q == MODE_BURST) steps_nx = steps_q - STEP_W'(1);
        if (mode_q == MODE_BURST && steps_q == STEP_W'(1)) begin
          state_nx = ST_FLUSH;
        end else if (gap_q == '0) begin
          state_nx = ST_PULSE;
        end else begin
          state_nx = ST_GAP;
          gcnt_nx  = gap_q;
        end
      end
      ST_GAP: begin
        gcnt_nx = gcnt_q - GAP_W'(1);
        if (gcnt_q == GAP_W'(1)) state_nx = ST_PULSE;
      end
      ST_FLUSH: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BURST;
      steps_q <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_nx;
      mode_q  <= mode_nx;
      steps_q <= steps_nx;
      gap_q   <= gap_nx;
      gcnt_q  <= gcnt_nx;
    end
  end

  // Outputs are registered from the next state so cen never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cen  <= (state_nx == ST_PULSE);
      busy <= (state_nx == ST_PULSE) || (state_nx == ST_GAP) || (state_nx == ST_FLUSH);
      done <= (state_nx == ST_DONE);
    end
  end

  // The check trails every cen cycle by one, independent of state, so the
  // last burst pulse and a pulse in an abort cycle are both still checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_pend_q <= 1'b0;
      prev_q     <= '0;
      err        <= 1'b0;
    end else begin
      chk_pend_q <= cen;
      if (accept) begin
        err    <= 1'b0;
        prev_q <= count_in;
      end else if (chk_pend_q) begin
        if (!step_ok) err <= 1'b1;
        prev_q <= count_in;
      end
    end
  end

endmodule

// File: tb/tb_cntr_gray_seq.sv
// Scoreboard bench for cntr_gray_seq driving a behavioural Gray counter.
module tb_cntr_gray_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] steps;
  logic [3:0] gap;
  logic       abort;
  logic [3:0] count_in;
  logic       cen;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] bin;
  logic       cnt_clr;
  logic       dbl;
  int         cyc;
  int         n_tests;
  int         n_fail;

  typedef struct {
    int         cyc;
    logic       err;
    logic [3:0] cnt;
  } done_t;

  int    cen_exp[$];
  done_t done_exp[$];

  cntr_gray_seq #(
    .WIDTH  (4),
    .STEP_W (8),
    .GAP_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .steps    (steps),
    .gap      (gap),
    .abort    (abort),
    .count_in (count_in),
    .cen      (cen),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for cntr_gray; dbl makes it skip a code to plant a two-bit jump.
  always @(posedge clk) begin
    if (cnt_clr)  bin <= 4'd0;
    else if (cen) bin <= bin + (dbl ? 4'd2 : 4'd1);
  end
  assign count_in = bin ^ (bin >> 1);

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] gray_after(input logic [3:0] b, input int n);
    logic [31:0] t;
    logic [3:0]  x;
    t = 32'(b) + 32'(n);
    x = t[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cen) begin
      if (cen_exp.size() == 0) check("cen_unexp", 32'(cen), 32'd0);
      else                     check("cen_cyc", 32'(cyc), 32'(cen_exp.pop_front()));
    end
    if (done) begin
      if (done_exp.size() == 0) begin
        check("done_unexp", 32'(done), 32'd0);
      end else begin
        done_t e;
        e = done_exp.pop_front();
        check("done_cyc", 32'(cyc), 32'(e.cyc));
        check("done_err", 32'(err), 32'(e.err));
        check("done_cnt", 32'(count_in), 32'(e.cnt));
        check("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic start_cmd(input logic md, input logic [7:0] st, input logic [3:0] gp,
                           input int n_cen, input logic push_done, input logic exp_err,
                           input logic [3:0] exp_cnt, output int m);
    done_t d;
    @(negedge clk);
    m = cyc;
    for (int i = 0; i < n_cen; i++) cen_exp.push_back(m + 1 + i * (32'(gp) + 1));
    if (push_done) begin
      d.cyc = (n_cen == 0) ? m + 1 : m + 1 + (n_cen - 1) * (32'(gp) + 1) + 2;
      d.err = exp_err;
      d.cnt = exp_cnt;
      done_exp.push_back(d);
    end
    start = 1'b1;
    mode  = md;
    steps = st;
    gap   = gp;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && (cen_exp.size() != 0 || done_exp.size() != 0); i++)
      @(negedge clk);
    check("drain", 32'(cen_exp.size() + done_exp.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    steps   = 8'd0;
    gap     = 4'd0;
    abort   = 1'b0;
    dbl     = 1'b0;
    cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    cnt_clr = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("rst_cen",  32'(cen),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);

    // Back-to-back burst of five from 0000, ends at 0111.
    start_cmd(1'b0, 8'd5, 4'd0, 5, 1'b1, 1'b0, 4'b0111, m);
    check("b5_busy", 32'(busy), 32'd1);
    wait_drain(40);

    // Burst with gap 2.
    start_cmd(1'b0, 8'd3, 4'd2, 3, 1'b1, 1'b0, gray_after(bin, 3), m);
    wait_drain(40);

    // Continuous run, aborted in the cycle of the 20th pulse; wraps past 1000.
    begin
      logic [3:0] b0;
      b0 = bin;
      start_cmd(1'b1, 8'd0, 4'd0, 20, 1'b0, 1'b0, 4'd0, m);
      while (cyc < m + 20) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_cen",  32'(cen),  32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("cont_err", 32'(err), 32'd0);
      check("cont_cnt", 32'(count_in), 32'(gray_after(b0, 20)));
      wait_drain(10);
    end

    // Planted 0001 -> 0010 jump on the second pulse.
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    start_cmd(1'b0, 8'd3, 4'd0, 3, 1'b1, 1'b1, gray_after(4'd0, 4), m);
    @(negedge clk);
    dbl = 1'b1;
    @(negedge clk);
    dbl = 1'b0;
    wait_drain(20);
    check("err_sticky", 32'(err), 32'd1);
    start_cmd(1'b0, 8'd1, 4'd0, 1, 1'b1, 1'b0, gray_after(bin, 1), m);
    check("err_clr", 32'(err), 32'd0);
    wait_drain(20);

    // Zero-step burst: done at k+1, no cen, never busy.
    start_cmd(1'b0, 8'd0, 4'd0, 0, 1'b1, 1'b0, count_in, m);
    check("zero_busy", 32'(busy), 32'd0);
    wait_drain(10);

    // Start while busy must not disturb the running burst.
    start_cmd(1'b0, 8'd4, 4'd1, 4, 1'b1, 1'b0, gray_after(bin, 4), m);
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    steps = 8'd9;
    gap   = 4'd0;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);

    // Start with abort in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    mode  = 1'b0;
    steps = 8'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_cen",  32'(cen),  32'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset while in GAP, then a fresh burst.
    start_cmd(1'b0, 8'd4, 4'd3, 4, 1'b1, 1'b0, 4'd0, m);
    @(negedge clk);
    check("gap_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cen",  32'(cen),  32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err",  32'(err),  32'd0);
    cen_exp.delete();
    done_exp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    start_cmd(1'b0, 8'd2, 4'd0, 2, 1'b1, 1'b0, gray_after(bin, 2), m);
    wait_drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
